// File: rtl/scope_pkg.sv
// scope_pkg: register map, CTRL bit positions and capture state type shared by the scope sample writer.
package scope_pkg;
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LEVEL  = 2'd1;
    localparam logic [1:0] ADDR_DECIM  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_SLOPE  = 2;
    localparam int CTRL_AUTO   = 3;
    localparam int CTRL_IRQ_EN = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_CAPTURE} state_t;
endpackage

// File: rtl/scope_trigger_detect.sv
// scope_trigger_detect: remembers the previous kept sample and flags a level crossing on the selected slope.
module scope_trigger_detect #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              kept_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] level_i,
    input  logic              slope_i,
    output logic              trig_o
);
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (clear_i) begin
            prev_valid_q <= 1'b0;
        end else if (kept_i) begin
            prev_q       <= sample_i;
            prev_valid_q <= 1'b1;
        end
    end

    assign trig_o = kept_i && prev_valid_q &&
                    (slope_i ? (prev_q > level_i && sample_i <= level_i)
                             : (prev_q < level_i && sample_i >= level_i));
endmodule

// File: rtl/scope_sample_writer.sv
// scope_sample_writer: decimating, level-triggered ADC capture into an external FIFO, controlled over Avalon-MM.
// Define SCOPE_SAMPLE_WRITER_IRQ_EN to build the capture-done interrupt and the stored CTRL.irq_en bit.
module scope_sample_writer
    import scope_pkg::*;
#(
    parameter int SAMPLES = 512,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              fifo_full,
    output logic              fifo_wrreq,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              irq
);
    localparam logic [15:0] N_LAST = 16'(SAMPLES);

    state_t            state_q;
    logic              slope_q, auto_q, irq_en_q, done_q, ovf_q;
    logic [DATA_W-1:0] level_q;
    logic [15:0]       decim_q, dcnt_q, count_q;
    logic              ctrl_wr, start_p, abort_p, count_en, kept, trig, take;
    logic [31:0]       rdata_d;
    logic              unused_wd;

    assign ctrl_wr  = write && address == ADDR_CTRL;
    assign abort_p  = ctrl_wr && writedata[CTRL_ABORT];
    assign start_p  = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_ABORT] && state_q == ST_IDLE;
    // the auto-arm cycle consumes no sample, so decimation stays parked there
    assign count_en = state_q == ST_CAPTURE || (state_q == ST_ARM && !auto_q);
    assign kept     = adc_valid && count_en && dcnt_q == 16'd0;
    assign take     = kept && !abort_p && (state_q == ST_CAPTURE || trig);
    assign unused_wd = ^writedata[31:16];

    assign rdata_d = address == ADDR_CTRL  ? {27'b0, irq_en_q, auto_q, slope_q, 2'b0}
                   : address == ADDR_LEVEL ? 32'(level_q)
                   : address == ADDR_DECIM ? {16'b0, decim_q}
                   : {count_q, 13'b0, ovf_q, done_q, state_q != ST_IDLE};

    scope_trigger_detect #(.DATA_W(DATA_W)) u_trig (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (start_p),
        .kept_i   (kept),
        .sample_i (adc_data),
        .level_i  (level_q),
        .slope_i  (slope_q),
        .trig_o   (trig)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            slope_q    <= 1'b0;
            auto_q     <= 1'b0;
            level_q    <= '0;
            decim_q    <= '0;
            dcnt_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            readdata   <= '0;
            fifo_wrreq <= 1'b0;
            fifo_wdata <= '0;
        end else begin
            readdata   <= rdata_d;
            fifo_wrreq <= 1'b0;
            if (ctrl_wr) begin
                slope_q <= writedata[CTRL_SLOPE];
                auto_q  <= writedata[CTRL_AUTO];
            end
            if (write && address == ADDR_LEVEL) level_q <= writedata[DATA_W-1:0];
            if (write && address == ADDR_DECIM) decim_q <= writedata[15:0];
            if (write && address == ADDR_STATUS) begin
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end
            if (adc_valid && count_en) dcnt_q <= dcnt_q == decim_q ? 16'd0 : dcnt_q + 16'd1;
            if (abort_p) begin
                state_q <= ST_IDLE;
            end else if (start_p) begin
                state_q <= ST_ARM;
                count_q <= '0;
                dcnt_q  <= '0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else if (state_q == ST_ARM && auto_q) begin
                state_q <= ST_CAPTURE;
            end else if (take) begin
                state_q <= ST_CAPTURE;
                if (fifo_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    fifo_wrreq <= 1'b1;
                    fifo_wdata <= adc_data;
                    count_q    <= count_q + 16'd1;
                    if (count_q + 16'd1 == N_LAST) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SCOPE_SAMPLE_WRITER_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
            irq <= done_q & irq_en_q;
        end
    end
`else
    assign irq_en_q = 1'b0;
    assign irq      = 1'b0;
`endif
endmodule

// File: doc/scope_sample_writer.md
# scope_sample_writer

Capture-side producer for the scope sample FIFO. Accepts 8-bit ADC samples, decimates them, waits for a level trigger on a programmable slope, then writes a fixed-length record into the external sample FIFO. The CPU's FIFO data input port later reads that record from the other end. Control and status are exposed on a small Avalon-MM slave on the same clock.

## Interface
Parameters:
- SAMPLES, 512: samples written per capture record; range 1..65535.
- DATA_W, 8: ADC and FIFO data width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  2  Avalon register select.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered Avalon read data.
- adc_data  in  DATA_W  ADC sample.
- adc_valid  in  1  one-cycle strobe; adc_data is valid while high.
- fifo_full  in  1  external FIFO full flag.
- fifo_wrreq  out  1  FIFO write request, one cycle per sample.
- fifo_wdata  out  DATA_W  FIFO write data.
- irq  out  1  capture-done interrupt (see Configuration).

## Operation
Register map:
- 0, CTRL, write only; reads return {27'b0, irq_en, auto, slope, 2'b0}.
  - bit0 start: write-1 pulse.
  - bit1 abort: write-1 pulse.
  - bit2 slope: 0 = rising, 1 = falling; stored.
  - bit3 auto: trigger immediately; stored.
  - bit4 irq_en: stored.
- 1, LEVEL: [DATA_W-1:0] trigger level, read/write.
- 2, DECIM: [15:0]; the block keeps one of every DECIM+1 valid samples. Read/write.
- 3, STATUS, read:
  - bit0 busy.
  - bit1 done.
  - bit2 overflow.
  - [31:16] samples written in the current/last record.
  - Any write to address 3 clears done and overflow.

State machine: IDLE, ARM, CAPTURE.
- IDLE → ARM on start. On entry to ARM: count=0, decimation counter=0, prev_valid=0, done=0, overflow=0.
- ARM → CAPTURE:
  - If auto=1: next cycle, with no sample consumed.
  - Otherwise: on a kept sample s with prev_valid=1 and a trigger condition:
    - rising: prev < LEVEL and s >= LEVEL;
    - falling: prev > LEVEL and s <= LEVEL.
  - The trigger sample is the first sample written.
- CAPTURE: each kept sample is written if fifo_full=0. If fifo_full=1, the sample is dropped, overflow is set (sticky), and count is not incremented.
- CAPTURE → IDLE when count reaches SAMPLES; done is set.
- Abort from any state → IDLE; done is not set, and count keeps its value.
- start while busy is ignored. start and abort in the same write: abort wins.
- Decimation: a counter counts adc_valid strobes 0..DECIM. A sample is kept when the counter is 0, and the counter wraps after DECIM. DECIM=0 keeps every sample.
- Comparisons are unsigned DATA_W-bit.

## Timing
- Reset values:
  - readdata=0, fifo_wrreq=0, fifo_wdata=0, irq=0.
  - state IDLE.
  - CTRL stored bits=0, LEVEL=0, DECIM=0.
  - done, overflow and count = 0.
- readdata is registered every cycle from address, with no read strobe: valid one cycle after address.
- Register writes take effect at the next clock edge. A start write puts the block in ARM at the next edge.
- fifo_wrreq/fifo_wdata are registered: asserted the cycle after the qualifying adc_valid, for exactly one cycle.
- fifo_full is sampled in the same cycle as adc_valid.
- The last write and the state change to IDLE/done=1 occur at the same edge.
- A start issued in the cycle done is set is accepted.
- Abort coinciding with a qualifying sample: the sample is not written.

## Configuration
- SCOPE_SAMPLE_WRITER_IRQ_EN defined:
  - irq is registered, irq = done & irq_en.
  - It asserts the cycle after done sets.
  - It clears the cycle after the STATUS write or after irq_en is cleared.
- Not defined:
  - irq is tied 0.
  - CTRL bit4 is not stored and reads 0.
  - The port remains present.

## Structure
- Shared package scope_pkg holds:
  - the register address constants (CTRL, LEVEL, DECIM, STATUS);
  - the CTRL bit indices;
  - the state enum typedef.
- Sub-module scope_trigger_detect: holds prev sample and prev_valid, and produces the one-cycle trig pulse from LEVEL/slope/kept-sample inputs.

## Test plan
- Auto capture, SAMPLES=4, DECIM=0, samples 10,20,30,40,50 → FIFO receives 10,20,30,40; done=1; STATUS[31:16]=4.
- Rising trigger with LEVEL=0x80, samples 0x10,0x7F,0x80,0x90 → first FIFO write is 0x80. A 0x80 arriving as the first sample after arm does not trigger.
- DECIM=2, auto, samples 1..9 → writes 1,4,7.
- fifo_full held high for the second kept sample → that sample is dropped, overflow=1, and the record still completes with SAMPLES writes.
- Abort in CAPTURE after 2 writes → IDLE, done=0, busy=0, no further wrreq. Start and abort in one write → stays IDLE.
- With SCOPE_SAMPLE_WRITER_IRQ_EN and irq_en=1: irq rises one cycle after done and falls after a STATUS write. Without the macro: irq stays 0 throughout.
